rx_ctrlmod: RTL

//  Sequencer and buffer for the UART receive function module. Drives its call

---
 rtl/rx_ctrlmod_if.sv | 30 +++
 rtl/rx_ctrlmod.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/rx_ctrlmod_if.sv
// Handshake bundle between rx_ctrlmod and its environment: receiver call/done
// pair, serial-line monitor and the downstream FIFO read port.
interface rx_ctrlmod_if #(
    parameter int AW = 4
);
    logic          iEnable;
    logic          oCall;
    logic          iDone;
    logic [7:0]    iData;
    logic          iRXD;
    logic          iRead;
    logic          iClear;
    logic [7:0]    oData;
    logic          oEmpty;
    logic          oFull;
    logic [AW:0]   oCount;
    logic          oOverflow;
    logic          oBusy;
    logic          oGap;

    modport master (
        output iEnable, iDone, iData, iRXD, iRead, iClear,
        input  oCall, oData, oEmpty, oFull, oCount, oOverflow, oBusy, oGap
    );

    modport slave (
        input  iEnable, iDone, iData, iRXD, iRead, iClear,
        output oCall, oData, oEmpty, oFull, oCount, oOverflow, oBusy, oGap
    );
endinterface

// File: rtl/rx_ctrlmod.sv
// UART receive sequencer with show-ahead byte FIFO and clean start/stop.
// Optional idle-gap pulse on oGap is compiled in with `define RX_GAP_TIMEOUT_EN.
module rx_ctrlmod #(
    parameter int DEPTH        = 16,
    parameter int AW           = 4,
    parameter int FRAME_CYCLES = 5208,
    parameter int GAP_CYCLES   = 4340
) (
    input  logic         CLOCK,
    input  logic         RESET,
    rx_ctrlmod_if.slave  bus
);
    localparam int            SW         = $clog2(FRAME_CYCLES);
    localparam logic [SW-1:0] FRAME_LAST = SW'(FRAME_CYCLES - 1);
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);

    if (DEPTH != (1 << AW) || DEPTH < 2 || FRAME_CYCLES < 2 || GAP_CYCLES < 2) begin : gParamCheck
        $error("rx_ctrlmod: inconsistent DEPTH/AW or timeout parameters");
    end

    typedef enum logic [1:0] {IDLE, RUN, STOP, DONE} state_t;

    state_t        state;
    logic          callQ;
    logic          busyQ;
    logic [SW-1:0] stopCnt;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic [AW:0]   count;
    logic          overflowQ;

    logic          empty;
    logic          full;
    logic          pushReq;
    logic          popReq;
    logic          wrEn;
    logic          dropped;

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign pushReq = bus.iDone && (state == RUN || state == STOP);
    assign popReq  = bus.iRead && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
    assign wrEn    = pushReq && (!full || popReq);
    assign dropped = pushReq && full && !popReq;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state   <= IDLE;
            callQ   <= 1'b0;
            busyQ   <= 1'b0;
            stopCnt <= '0;
        end else begin
            unique case (state)
                IDLE: if (bus.iEnable) begin
                    state <= RUN;
                    callQ <= 1'b1;
                    busyQ <= 1'b1;
                end
                RUN: if (!bus.iEnable) begin
                    state   <= STOP;
                    stopCnt <= '0;
                end
                STOP: begin
                    if (stopCnt < FRAME_LAST) stopCnt <= stopCnt + 1'b1;
                    // Wait for the frame in flight, or a full frame of idle line.
                    if (bus.iDone || (stopCnt >= FRAME_LAST && bus.iRXD)) begin
                        state <= DONE;
                        busyQ <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    callQ <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: the storage array has no reset; only pointers and count define
    // which entries are valid, and oData is masked to 0 while empty.
    always_ff @(posedge CLOCK) begin
        if (wrEn && !bus.iClear) mem[wrPtr] <= bus.iData;
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            count     <= '0;
            overflowQ <= 1'b0;
        end else if (bus.iClear) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            count     <= '0;
            overflowQ <= 1'b0;
        end else begin
            if (wrEn)   wrPtr <= wrPtr + 1'b1;
            if (popReq) rdPtr <= rdPtr + 1'b1;
            case ({wrEn, popReq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (dropped) overflowQ <= 1'b1;
        end
    end

`ifdef RX_GAP_TIMEOUT_EN
    localparam int            GW       = $clog2(GAP_CYCLES + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [GW-1:0] GAP_MAX  = GW'(GAP_CYCLES);

    logic [GW-1:0] gapCnt;
    logic          gapQ;

    // Saturating at GAP_CYCLES means GAP_LAST is passed once per gap.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            gapCnt <= '0;
            gapQ   <= 1'b0;
        end else if (bus.iClear) begin
            gapCnt <= '0;
            gapQ   <= 1'b0;
        end else begin
            gapQ <= (gapCnt == GAP_LAST) && !empty;
            if (wrEn)                  gapCnt <= '0;
            else if (gapCnt != GAP_MAX) gapCnt <= gapCnt + 1'b1;
        end
    end

    assign bus.oGap = gapQ;
`else
    assign bus.oGap = 1'b0;
`endif

    assign bus.oCall     = callQ;
    assign bus.oBusy     = busyQ;
    assign bus.oData     = empty ? 8'h00 : mem[rdPtr];
    assign bus.oEmpty    = empty;
    assign bus.oFull     = full;
    assign bus.oCount    = count;
    assign bus.oOverflow = overflowQ;
endmodule
